// File: rtl/layer2_mac_sequencer.sv
// Layer-2 fully-connected sequencer: walks each neuron's weight row against the
// layer-1 activations, one MAC per cycle, and hands each result out on valid/ready.
module layer2_mac_sequencer #(
  parameter  int N_IN  = 16,
  parameter  int N_OUT = 16,
  parameter  int ACC_W = 44,
  parameter  int RELU  = 0,
  localparam int KW    = $clog2(N_IN),
  localparam int NW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [7:0]    w_addr,
  input  logic [19:0]   w_data,
  output logic [KW-1:0] x_addr,
  input  logic [19:0]   x_data,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [NW-1:0] y_idx,
  output logic [19:0]   y_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_OUT,
    S_FIN
  } state_t;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(524287);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-524288);

  state_t                   r_state;
  state_t                   w_next;
  logic [NW-1:0]            r_neuron;
  logic [KW-1:0]            r_k;
  logic signed [39:0]       r_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic [19:0]              r_y_data;
  logic [NW-1:0]            r_y_idx;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_valid;

  logic signed [19:0]       w_x;
  logic signed [19:0]       w_mag;
  logic signed [19:0]       w_wtc;
  logic signed [39:0]       w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_sh;
  logic [19:0]              w_y;

  // Sign-magnitude weight to two's complement; a -0 word decodes to 0.
  assign w_x        = x_data;
  assign w_mag      = {1'b0, w_data[18:0]};
  assign w_wtc      = w_data[19] ? -w_mag : w_mag;
  assign w_prod     = 40'(w_x) * 40'(w_wtc);
  assign w_prod_ext = {{(ACC_W-40){r_prod[39]}}, r_prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_sh       = w_sum >>> 16;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_y = w_sh[19:0];
    if (w_sh > Y_MAX)      w_y = 20'h7FFFF;
    else if (w_sh < Y_MIN) w_y = 20'h80000;
    if (RELU != 0 && w_sh[ACC_W-1]) w_y = '0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_MAC;
      S_MAC:   if (r_k == KW'(N_IN - 1)) w_next = S_DRAIN;
      S_DRAIN: w_next = S_OUT;
      S_OUT:   if (y_ready) w_next = (r_neuron == NW'(N_OUT - 1)) ? S_FIN : S_MAC;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Status flags are registered from the next state so they change with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_next == S_MAC) || (w_next == S_DRAIN) || (w_next == S_OUT);
      r_done  <= (w_next == S_FIN);
      r_valid <= (w_next == S_OUT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neuron <= '0;
      r_k      <= '0;
      r_prod   <= '0;
      r_acc    <= '0;
      r_y_data <= '0;
      r_y_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_neuron <= '0;
            r_k      <= '0;
          end
        end
        S_MAC: begin
          // The product lags the address by one cycle, so k==0 clears instead of adding.
          r_prod <= w_prod;
          r_acc  <= (r_k == '0) ? '0 : w_sum;
          r_k    <= r_k + 1'b1;
        end
        S_DRAIN: begin
          r_acc    <= w_sum;
          r_y_data <= w_y;
          r_y_idx  <= r_neuron;
        end
        S_OUT: begin
          if (y_ready && (r_neuron != NW'(N_OUT - 1))) r_neuron <= r_neuron + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_addr  = 8'({r_neuron, r_k});
  assign x_addr  = r_k;
  assign busy    = r_busy;
  assign done    = r_done;
  assign y_valid = r_valid;
  assign y_idx   = r_y_idx;
  assign y_data  = r_y_data;

endmodule

// File: tb/tb_layer2_mac_sequencer.sv
// Self-checking bench for layer2_mac_sequencer: behavioural ROM/activation memories,
// a scoreboard of expected neuron results, and a RELU=1 twin run in lockstep.
module tb_layer2_mac_sequencer;

  localparam int N_IN  = 16;
  localparam int N_OUT = 16;

  typedef struct {
    logic [3:0]  idx;
    logic [19:0] y;
    logic [19:0] yr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        y_ready;

  logic        busy, done, y_valid;
  logic [7:0]  w_addr;
  logic [19:0] w_data, x_data, y_data;
  logic [3:0]  x_addr, y_idx;

  logic        busy_r, done_r, yr_valid;
  logic [7:0]  w_addr_r;
  logic [19:0] w_data_r, x_data_r, yr_data;
  logic [3:0]  x_addr_r, yr_idx;

  logic [19:0] rom  [256];
  logic [19:0] xmem [N_IN];

  exp_t        exp_q[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          hs_cnt  = 0;
  int          done_cnt = 0;
  logic [19:0] last_y, last_yr, y0;

  assign w_data   = rom[w_addr];
  assign x_data   = xmem[x_addr];
  assign w_data_r = rom[w_addr_r];
  assign x_data_r = xmem[x_addr_r];

  layer2_mac_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(44), .RELU(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_addr(w_addr), .w_data(w_data), .x_addr(x_addr), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_idx(y_idx), .y_data(y_data)
  );

  layer2_mac_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(44), .RELU(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_r), .done(done_r),
    .w_addr(w_addr_r), .w_data(w_data_r), .x_addr(x_addr_r), .x_data(x_data_r),
    .y_valid(yr_valid), .y_ready(y_ready), .y_idx(yr_idx), .y_data(yr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] model_y(input int n, input bit relu);
    longint acc;
    longint w;
    longint x;
    longint r;
    logic [19:0] wd;
    acc = 0;
    for (int i = 0; i < N_IN; i++) begin
      wd  = rom[n*N_IN + i];
      w   = longint'(wd[18:0]);
      if (wd[19]) w = -w;
      x   = longint'($signed(xmem[i]));
      acc = acc + x * w;
    end
    r = acc >>> 16;
    if (r > 524287)       r = 524287;
    else if (r < -524288) r = -524288;
    if (relu && r < 0)    r = 0;
    return r[19:0];
  endfunction

  task automatic push_layer();
    exp_t t;
    for (int n = 0; n < N_OUT; n++) begin
      t.idx = 4'(n);
      t.y   = model_y(n, 1'b0);
      t.yr  = model_y(n, 1'b1);
      exp_q.push_back(t);
    end
  endtask

  task automatic fill(input logic [19:0] w, input logic [19:0] x);
    for (int i = 0; i < 256; i++) rom[i] = w;
    for (int i = 0; i < N_IN; i++) xmem[i] = x;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) rom[i] = 20'($urandom);
    for (int i = 0; i < N_IN; i++) xmem[i] = 20'($urandom);
  endtask

  // Scoreboard: every accepted result is popped and compared on the same edge.
  always @(negedge clk) begin
    if (rst_n && y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("y_idx", 64'(y_idx), 64'(e.idx));
        check("y_data", 64'(y_data), 64'(e.y));
        check("relu_valid", 64'(yr_valid), 64'd1);
        check("relu_idx", 64'(yr_idx), 64'(e.idx));
        check("relu_data", 64'(yr_data), 64'(e.yr));
      end
      last_y  = y_data;
      last_yr = yr_data;
      if (y_idx == 4'd0) y0 = y_data;
      hs_cnt++;
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic run_layer(input int stall);
    int cyc, mac_t, val_t, done_t, s;
    bit got_mac, got_val, got_done;
    logic [19:0] cap_y;
    logic [3:0]  cap_idx;
    logic [7:0]  cap_a;
    cyc = 0; mac_t = 0; val_t = 0; done_t = 0; s = 0;
    got_mac = 0; got_val = 0; got_done = 0;
    cap_y = '0; cap_idx = '0; cap_a = '0;
    push_layer();
    @(posedge clk); #1; start = 1'b1; y_ready = (stall == 0);
    @(posedge clk); #1; start = 1'b0;
    while (!got_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!got_mac && busy)    begin got_mac = 1; mac_t = cyc; end
      if (!got_val && y_valid) begin got_val = 1; val_t = cyc; end
      if (done) begin
        got_done = 1;
        done_t   = cyc;
        check("busy_at_done", 64'(busy), 64'd0);
      end
      if (s < stall && y_valid) begin
        if (s == 0) begin
          cap_y = y_data; cap_idx = y_idx; cap_a = w_addr;
        end else begin
          check("stall_valid", 64'(y_valid), 64'd1);
          check("stall_data", 64'(y_data), 64'(cap_y));
          check("stall_idx", 64'(y_idx), 64'(cap_idx));
          check("stall_waddr", 64'(w_addr), 64'(cap_a));
        end
        s++;
      end
      @(posedge clk); #1;
      start = (stall > 0) && (s == 2);
      if (s == stall) y_ready = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 64'(got_done), 64'd1);
    check("mac_start", 64'(mac_t), 64'd1);
    check("first_valid_lat", 64'(val_t - mac_t), 64'(N_IN + 1));
    check("run_cycles", 64'(done_t - mac_t), 64'(288 + stall));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int base, cnt0, wcnt;
    rst_n = 1'b0; start = 1'b0; y_ready = 1'b1;
    last_y = '0; last_yr = '0; y0 = '0;
    fill(20'h0, 20'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(y_valid), 64'd0);
    check("rst_waddr", 64'(w_addr), 64'd0);
    check("rst_xaddr", 64'(x_addr), 64'd0);
    check("rst_yidx", 64'(y_idx), 64'd0);
    check("rst_ydata", 64'(y_data), 64'd0);
    rst_n = 1'b1;

    // Saturation: +1.0 * +1.0 summed 16 times clips to the positive rail.
    fill(20'h10000, 20'h10000);
    run_layer(0);
    check("sat_last", 64'(last_y), 64'h7FFFF);
    check("sat_idx_count", 64'(hs_cnt), 64'd16);

    // -1.0 * 0.5 summed 16 times lands exactly on -8.0; RELU clamps it.
    fill(20'h90000, 20'h08000);
    run_layer(0);
    check("neg_exact", 64'(last_y), 64'h80000);
    check("relu_neg", 64'(last_yr), 64'h00000);

    // Sign-magnitude -0 contributes nothing.
    fill(20'h80000, 20'h08000);
    run_layer(0);
    check("neg_zero", 64'(last_y), 64'h00000);

    // Real ROM row 0 decode with one-hot activations.
    fill_random();
    rom[0] = 20'h13333; rom[1] = 20'hB3333; rom[2] = 20'h20000; rom[3] = 20'h9999A;
    for (int i = 0; i < N_IN; i++) xmem[i] = 20'h0;
    xmem[2] = 20'h10000;
    run_layer(0);
    check("row0_idx2", 64'(y0), 64'h20000);
    xmem[2] = 20'h0;
    xmem[3] = 20'h10000;
    run_layer(0);
    check("row0_idx3", 64'(y0), 64'hE6666);

    // Backpressure on neuron 0 with a stray start; then the same data unstalled.
    fill_random();
    run_layer(5);
    run_layer(0);

    // Reset in the middle of neuron 3's MAC phase abandons the run.
    fill_random();
    base = hs_cnt;
    push_layer();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wcnt = 0;
    while (hs_cnt < base + 3 && wcnt < 500) begin
      @(posedge clk);
      wcnt++;
    end
    check("abort_reached", 64'(hs_cnt - base), 64'd3);
    repeat (5) @(posedge clk);
    #2;
    cnt0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_valid", 64'(y_valid), 64'd0);
    check("abort_waddr", 64'(w_addr), 64'd0);
    check("abort_xaddr", 64'(x_addr), 64'd0);
    check("abort_yidx", 64'(y_idx), 64'd0);
    check("abort_ydata", 64'(y_data), 64'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(cnt0));
    check("abort_idle", 64'(busy), 64'd0);
    run_layer(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
